// File: rtl/outmem_pkg.sv
// Shared constants and FSM state type for the output-memory port B reader.
package outmem_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_e;

endpackage

// File: rtl/outmem_rd_fifo.sv
// Two-entry read-return FIFO; entry 0 is the head register that drives the stream.
module outmem_rd_fifo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + 2'(push_i) - 2'(pop_i);
    unique case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) head_d = din_i;
        else                 tail_d = din_i;
      end
      2'b01: head_d = tail_q;
      2'b11: begin
        // Simultaneous push/pop: with one entry the new word becomes the head directly.
        if (count_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign head_o  = head_q;

endmodule

// File: rtl/outmem_port_b_reader.sv
// Port B read master: fetches a block of consecutive words and streams them out with a last flag.
module outmem_port_b_reader
  import outmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = outmem_pkg::ADDR_W,
  parameter int unsigned DATA_W     = outmem_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              outmem_en_b_o,
  output logic              outmem_we_b_o,
  output logic [ADDR_W-1:0] outmem_addr_b_o,
  output logic [DATA_W-1:0] outmem_data_b_o,
  input  logic [DATA_W-1:0] outmem_data_b_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] pop_cnt_q, pop_cnt_d;
  logic              inflight_q;

  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;

  outmem_rd_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (inflight_q),
    .din_i  (outmem_data_b_i),
    .pop_i  (pop),
    .count_o(fifo_count),
    .valid_o(fifo_valid),
    .head_o (m_data_o)
  );

  assign m_valid_o = fifo_valid;
  assign m_last_o  = fifo_valid && (pop_cnt_q == len_q - ADDR_W'(1));
  assign pop       = fifo_valid && m_ready_i;
  // Counting the pop in the same cycle lets a drained slot be refilled without a bubble.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    issue       = 1'b0;

    if (pop) pop_cnt_d = pop_cnt_q + ADDR_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          len_d       = len_i;
          issue_cnt_d = '0;
          pop_cnt_d   = '0;
          // A zero-length command passes through DRAIN so completion lands one cycle later.
          state_d     = (len_i != '0) ? READ : DRAIN;
        end
      end
      READ: begin
        issue = (occupancy < 3'(FIFO_DEPTH));
        if (issue) begin
          addr_d      = addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q + ADDR_W'(1);
          if (issue_cnt_q == len_q - ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((pop && m_last_o) || (!fifo_valid && !inflight_q)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= issue;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign outmem_en_b_o   = issue;
  assign outmem_we_b_o   = 1'b0;
  assign outmem_addr_b_o = addr_q;
  assign outmem_data_b_o = '0;

endmodule

// File: tb/tb_outmem_port_b_reader.sv
// Randomized bench: memory model on port B, scoreboard of expected words per command.
module tb_outmem_port_b_reader;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [13:0] base_addr_i;
  logic [13:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        outmem_en_b_o;
  logic        outmem_we_b_o;
  logic [13:0] outmem_addr_b_o;
  logic [31:0] outmem_data_b_o;
  logic [31:0] outmem_data_b_i;
  logic [31:0] m_data_o;
  logic        m_valid_o;
  logic        m_last_o;
  logic        m_ready_i;

  logic [31:0] mem [0:16383];
  int unsigned n_checks;
  int unsigned n_pass;

  outmem_port_b_reader #(
    .ADDR_W    (14),
    .DATA_W    (32),
    .FIFO_DEPTH(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .outmem_en_b_o  (outmem_en_b_o),
    .outmem_we_b_o  (outmem_we_b_o),
    .outmem_addr_b_o(outmem_addr_b_o),
    .outmem_data_b_o(outmem_data_b_o),
    .outmem_data_b_i(outmem_data_b_i),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_last_o       (m_last_o),
    .m_ready_i      (m_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port B memory: one-cycle read latency.
  always @(posedge clk) begin
    if (outmem_en_b_o) outmem_data_b_i <= mem[outmem_addr_b_o];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_en"}, 32'(outmem_en_b_o), 32'd0);
    chk({tag, "_we"}, 32'(outmem_we_b_o), 32'd0);
    chk({tag, "_addr"}, 32'(outmem_addr_b_o), 32'd0);
    chk({tag, "_wdata"}, outmem_data_b_o, 32'd0);
    chk({tag, "_valid"}, 32'(m_valid_o), 32'd0);
    chk({tag, "_last"}, 32'(m_last_o), 32'd0);
    chk({tag, "_data"}, m_data_o, 32'd0);
  endtask

  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return (c % 3) == 1;
    if (mode == 2) return $urandom_range(0, 3) != 0;
    return 1'b1;
  endfunction

  // mode: 0 ready always high, 1 ready pattern 1,0,0,..., 2 random ready.
  task automatic run_cmd(input logic [13:0] base, input int unsigned len, input int mode,
                         input int busy_start_at, input int reset_at);
    logic [31:0] exp_q[$];
    int unsigned issued, popped;
    int first_en, first_val, last_hs, done_c;
    logic stall_prev, stall_last;
    logic [31:0] stall_data;
    bit finished, aborted;
    logic [13:0] exp_addr;

    issued = 0; popped = 0;
    first_en = -1; first_val = -1; last_hs = -1; done_c = -1;
    stall_prev = 1'b0; stall_last = 1'b0; stall_data = '0;
    finished = 1'b0; aborted = 1'b0;
    for (int unsigned i = 0; i < len; i++) begin
      exp_addr = 14'(32'(base) + i);
      exp_q.push_back(mem[exp_addr]);
    end

    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; len_i = 14'(len); m_ready_i = 1'b1;
    @(negedge clk);
    chk("idle_before_start", 32'(busy_o), 32'd0);

    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start_i   = 1'b0;
      m_ready_i = ready_for(mode, c);
      if (c == busy_start_at) begin
        start_i = 1'b1; base_addr_i = ~base; len_i = 14'd3;
      end
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      chk("busy", 32'(busy_o), 32'd1);
      if (stall_prev) begin
        chk("hold_valid", 32'(m_valid_o), 32'd1);
        chk("hold_data", m_data_o, stall_data);
        chk("hold_last", 32'(m_last_o), 32'(stall_last));
      end
      stall_prev = m_valid_o && !m_ready_i;
      stall_data = m_data_o;
      stall_last = m_last_o;
      if (m_valid_o && first_val < 0) first_val = c;
      if (m_valid_o && m_ready_i) begin
        if (popped < len) begin
          chk("data", m_data_o, exp_q[popped]);
          chk("last", 32'(m_last_o), 32'(popped == len - 1));
        end else begin
          chk("extra_word", m_data_o, 32'hDEAD_BEEF ^ m_data_o ^ 32'h1);
        end
        popped++;
        last_hs = c;
      end
      if (outmem_en_b_o) begin
        exp_addr = 14'(32'(base) + issued);
        chk("en_addr", 32'(outmem_addr_b_o), 32'(exp_addr));
        if (first_en < 0) first_en = c;
        issued++;
        chk("issue_bound", 32'(issued <= len), 32'd1);
        chk("occupancy", 32'(issued - popped <= 2), 32'd1);
      end
      if (done_o) begin
        done_c = c;
        finished = 1'b1;
        break;
      end
    end

    if (aborted) return;
    if (!finished) begin
      chk("timeout_done", 32'd0, 32'd1);
      return;
    end
    chk("all_issued", issued, len);
    chk("all_popped", popped, len);
    if (len == 0) begin
      chk("zero_done_cycle", 32'(done_c), 32'd2);
      chk("zero_no_valid", 32'(first_val), 32'hFFFF_FFFF);
    end else begin
      chk("done_after_last", 32'(done_c), 32'(last_hs + 1));
      if (mode == 0) begin
        chk("first_en_cycle", 32'(first_en), 32'd1);
        chk("first_valid_cycle", 32'(first_val), 32'd3);
        chk("last_word_cycle", 32'(last_hs), 32'(len + 2));
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_done_busy", 32'(busy_o), 32'd0);
    chk("idle_after_done_pulse", 32'(done_o), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0; m_ready_i = 1'b1;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    run_cmd(14'h0010, 4, 0, -1, -1);
    chk("static_we", 32'(outmem_we_b_o), 32'd0);
    run_cmd(14'h0010, 4, 1, -1, -1);
    run_cmd(14'h3FFE, 4, 0, -1, -1);
    run_cmd(14'h3FFE, 4, 1, -1, -1);
    run_cmd(14'h0000, 0, 0, -1, -1);
    run_cmd(14'h0020, 6, 0, 2, -1);
    run_cmd(14'h0030, 5, 1, 4, -1);
    run_cmd(14'h0040, 8, 0, -1, 4);
    run_cmd(14'h0050, 2, 0, -1, -1);
    run_cmd(14'h3FFF, 1, 0, -1, -1);
    for (int k = 0; k < 25; k++) begin
      run_cmd(14'($urandom), $urandom_range(0, 12), 2, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
